apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
//  APB3 completer: word-addressed register memory answering the APB master's psel/penable/pwrite/paddr/pwdata.
//  Returns prdata/pready/pslverr with programmable wait states and error response on bad addresses.
//  Sits on the slave side of the APB bus as the bench's reference responder for master-side checks.
// PARAMETERS
//  ADDR_WIDTH  32      width of paddr
//  DATA_WIDTH  32      width of pwdata/prdata
//  MEM_DEPTH   256     number of DATA_WIDTH words
//  BASE_ADDR   32'h0   byte address of word 0
// PORTS
//  pclock    in   1           APB clock, all state on rising edge
//  preset    in   1           async reset, active-high
//  psel      in   1           slave select
//  penable   in   1           access phase
//  pwrite    in   1           1=write, 0=read
//  paddr     in   ADDR_WIDTH  byte address
//  pwdata    in   DATA_WIDTH  write data
//  wait_cfg  in   4           wait states inserted per transfer, sampled at setup
//  prdata    out  DATA_WIDTH  read data, valid only while pready=1
//  pready    out  1           transfer completes this cycle
//  pslverr   out  1           error response, valid only while pready=1
// BEHAVIOUR
//  Clocking: one clock (pclock); reset preset is asynchronous, active-high.
//  Reset: prdata=0, pready=0, pslverr=0, FSM=IDLE, wait counter=0, all memory words cleared to 0.
//  Reset mid-transfer: immediate return to IDLE, pending write dropped, outputs 0.
//  All outputs registered. prdata=0 and pslverr=0 whenever pready=0.
//  FSM states IDLE, WAIT, DONE:
//   IDLE: on psel&!penable sampled, capture paddr/pwrite/pwdata; cnt<=wait_cfg.
//     wait_cfg==0 -> DONE (pready=1 in first access cycle, zero-wait).
//     else -> WAIT.
//   WAIT: pready=0. cnt==1 -> DONE; else cnt--. Exactly wait_cfg access cycles with pready=0.
//   DONE: pready=1 for exactly one cycle; next edge -> IDLE, pready=0.
//  Address check (on captured addr):
//   error if paddr[1:0]!=0, paddr<BASE_ADDR, or paddr>=BASE_ADDR+4*MEM_DEPTH.
//   index = (paddr-BASE_ADDR)>>2, width clog2(MEM_DEPTH).
//  Read: DONE cycle drives prdata=mem[index]; error -> prdata=0, pslverr=1.
//  Write: committed on DONE edge when psel&penable&pwrite; error -> no write, pslverr=1.
//  Abort: psel=0 while in WAIT/DONE -> IDLE next edge, no write, pready=0.
//  penable=1 seen in IDLE without prior setup: ignored, stays IDLE.
//  Back-to-back: IDLE following DONE accepts the next setup phase immediately.
//   Min transfer = 2 cycles (setup + access), no idle cycle required.
//  Read after write to same address returns the new data.
// TESTING
//  1 wait_cfg=0: write 0xDEADBEEF @0x10, read @0x10 -> pready high in 1st access cycle, prdata=0xDEADBEEF, pslverr=0.
//  2 wait_cfg=3: read @0x10 -> exactly 3 access cycles with pready=0, then pready=1 one cycle, prdata=0xDEADBEEF.
//  3 write 0x1234 @0x400 (MEM_DEPTH=256) -> pslverr=1 with pready; read @0x3FC still returns prior value (0 after reset).
//  4 write @0x13 (misaligned) -> pslverr=1, mem[4] unchanged; following read @0x10 -> 0xDEADBEEF.
//  5 preset pulsed during WAIT of write @0x20 -> pready/pslverr/prdata=0 at once; read @0x20 afterwards -> 0.
//  6 back-to-back writes @0x0,@0x4 then reads, wait_cfg=1 -> each transfer 3 cycles, data intact, no dropped setup.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory.
// Answers setup/access phases with a programmable number of wait states and
// flags misaligned or out-of-window addresses with pslverr.
module apb_slave_mem #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                  pclock,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [3:0]            wait_cfg,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned AW1     = ADDR_WIDTH + 1;
   localparam int unsigned SPAN_B  = 4 * MEM_DEPTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Byte offset from the window base, one extra bit so an address below
   // the base wraps to a huge value and fails the upper-bound compare too.
   function automatic logic [AW1-1:0] offset_f(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} - AW1'(BASE_ADDR);
   endfunction

   function automatic logic addr_err_f(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || (offset_f(a) >= AW1'(SPAN_B));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx_f(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'(offset_f(a) >> 2);
   endfunction

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   wr_q, wr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;

   logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic                   sel_wr;
   logic                   sel_err;
   logic [IDX_W-1:0]       sel_idx;
   logic                   go_done;
   logic                   mem_we;

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

   // In IDLE the transfer is being captured this edge, so decode the live bus
   // address; afterwards decode the captured one.
   always_comb begin
      sel_addr = (state_q == S_IDLE) ? paddr  : addr_q;
      sel_wr   = (state_q == S_IDLE) ? pwrite : wr_q;
      sel_err  = addr_err_f(sel_addr);
      sel_idx  = addr_idx_f(sel_addr);
   end

   // Next-state, capture and registered-output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      go_done   = 1'b0;
      mem_we    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               cnt_d   = wait_cfg;
               if (wait_cfg == 4'd0) begin
                  state_d = S_DONE;
                  go_done = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!psel) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd1) begin
               state_d = S_DONE;
               go_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            mem_we  = psel && penable && wr_q && !sel_err;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_done) begin
         pready_d  = 1'b1;
         pslverr_d = sel_err;
         if (!sel_wr && !sel_err) begin
            prdata_d = mem_q[sel_idx];
         end
      end
   end

   // Control and output registers; reset abandons any transfer in flight.
   always_ff @(posedge pclock or posedge preset) begin
      if (preset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Storage array; a write lands on the edge that closes the DONE cycle.
   always_ff @(posedge pclock or posedge preset) begin
      if (preset) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[sel_idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized scoreboard bench for apb_slave_mem: a driver issues APB transfers
// and queues the reference model's expected response; a monitor pops and
// compares whenever the completer raises pready.
module tb_apb_slave_mem;

   localparam int unsigned DEPTH = 256;

   logic        pclock = 1'b0;
   logic        preset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  wait_cfg;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   apb_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (DEPTH),
      .BASE_ADDR  (32'h0)
   ) dut (
      .pclock   (pclock),
      .preset   (preset),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .wait_cfg (wait_cfg),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   always #5 pclock = ~pclock;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      logic        err;
      int unsigned waits;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_mem [DEPTH];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
   endtask

   function automatic logic model_err(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
   endtask

   // One complete transfer; returns after the pready cycle is sampled.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int unsigned w);
      exp_t e;
      int   cycles;
      bit   done;
      @(posedge pclock); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = 4'(w);
      e.is_read = !wr;
      e.err     = model_err(a);
      e.waits   = w;
      e.data    = (!wr && !e.err) ? model_mem[a / 4] : 32'h0;
      sb_q.push_back(e);
      @(posedge pclock); #1;
      penable = 1'b1;
      cycles = 1;
      done   = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge pclock);
         cycles++;
         if (pready) done = 1'b1;
      end
      if (!done) check("pready_timeout", 32'(pready), 32'h1);
      else       check("xfer_len", 32'(cycles), 32'(2 + w));
      if (done && wr && !e.err) model_mem[a / 4] = d;
   endtask

   task automatic bus_idle(input int n);
      @(posedge pclock); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (n) @(posedge pclock);
   endtask

   // Master drops psel during the wait phase: no response, no write.
   task automatic xfer_abort(input logic [31:0] a, input logic [31:0] d, input int unsigned w);
      @(posedge pclock); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; wait_cfg = 4'(w);
      @(posedge pclock); #1;
      penable = 1'b1;
      @(posedge pclock); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Access phase without a setup phase must be ignored.
   task automatic spurious_access(input logic [31:0] a, input logic [31:0] d);
      @(posedge pclock); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; wait_cfg = 4'd0;
      repeat (3) @(posedge pclock);
      #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Reset pulsed mid-transfer; n=0 hits the DONE cycle of a zero-wait transfer.
   task automatic xfer_reset(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input int unsigned w, input int n);
      @(posedge pclock); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = 4'(w);
      @(posedge pclock); #1;
      penable = 1'b1;
      if (n == 0) begin
         #1;
         check("pre_reset_pready", 32'(pready), 32'h1);
      end else begin
         repeat (n) @(negedge pclock);
         #2;
      end
      preset = 1'b1;
      #1;
      check("rst_pready", 32'(pready), 32'h0);
      check("rst_pslverr", 32'(pslverr), 32'h0);
      check("rst_prdata", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
      model_clear();
      @(negedge pclock); #1;
      preset = 1'b0;
   endtask

   // Monitor: wait-cycle accounting and response comparison against the queue.
   initial begin : monitor
      int   wcnt;
      exp_t e;
      wcnt = 0;
      forever begin
         @(negedge pclock);
         if (preset) begin
            wcnt = 0;
         end else if (pready && !(psel && penable)) begin
            check("pready_outside_access", 32'(pready), 32'h0);
         end else if (psel && !penable) begin
            wcnt = 0;
         end else if (psel && penable) begin
            if (!pready) begin
               wcnt++;
               check("wait_prdata_zero", prdata, 32'h0);
               check("wait_pslverr_zero", 32'(pslverr), 32'h0);
            end else if (sb_q.size() == 0) begin
               check("unexpected_pready", 32'(pready), 32'h0);
            end else begin
               e = sb_q.pop_front();
               if (e.is_read) check("prdata", prdata, e.data);
               check("pslverr", 32'(pslverr), 32'(e.err));
               check("wait_cycles", 32'(wcnt), 32'(e.waits));
               wcnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [31:0]  a;
      int unsigned  w;
      int unsigned  r;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; wait_cfg = '0;
      model_clear();
      repeat (2) @(posedge pclock);
      #1;
      check("reset_pready", 32'(pready), 32'h0);
      check("reset_pslverr", 32'(pslverr), 32'h0);
      check("reset_prdata", prdata, 32'h0);
      @(negedge pclock); #1;
      preset = 1'b0;

      // zero-wait write then read
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);
      xfer(1'b0, 32'h10, 32'h0, 0);
      // three wait states
      xfer(1'b0, 32'h10, 32'h0, 3);
      // just past the window, then the last valid word
      xfer(1'b1, 32'h400, 32'h1234, 0);
      xfer(1'b0, 32'h3FC, 32'h0, 1);
      // misaligned write must not disturb word 4
      xfer(1'b1, 32'h13, 32'hCAFEF00D, 2);
      xfer(1'b0, 32'h10, 32'h0, 0);
      bus_idle(1);
      spurious_access(32'h10, 32'h0BAD0BAD);
      xfer(1'b0, 32'h10, 32'h0, 0);
      bus_idle(1);
      xfer_abort(32'h10, 32'h55555555, 4);
      bus_idle(2);
      xfer(1'b0, 32'h10, 32'h0, 1);
      bus_idle(1);

      // reset during WAIT of a write, then during DONE of a read
      xfer_reset(1'b1, 32'h20, 32'hA5A5A5A5, 5, 2);
      xfer(1'b0, 32'h20, 32'h0, 0);
      bus_idle(1);
      xfer(1'b1, 32'h10, 32'h11223344, 0);
      xfer_reset(1'b0, 32'h10, 32'h0, 0, 0);
      xfer(1'b0, 32'h10, 32'h0, 2);

      // back-to-back with one wait state
      xfer(1'b1, 32'h0, 32'h01010101, 1);
      xfer(1'b1, 32'h4, 32'h02020202, 1);
      xfer(1'b0, 32'h0, 32'h0, 1);
      xfer(1'b0, 32'h4, 32'h0, 1);
      bus_idle(1);

      // randomized mix of reads, writes, errors and wait counts
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = 32'($urandom_range(0, 255)) * 4;
         else if (r == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
         else             a = $urandom;
         w = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
         xfer(1'($urandom_range(0, 1)), a, $urandom, w);
         if ($urandom_range(0, 4) == 0) bus_idle($urandom_range(0, 2));
      end

      bus_idle(3);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
